// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin two-requester sequencer for the daisy-chained core bus
module bus_arbiter #(
  parameter int TIMEOUT    = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] req0_addr_i,
  input  logic [DATA_WIDTH-1:0] req0_wdata_i,
  input  logic                  req0_rw_i,
  input  logic                  req0_valid_i,
  output logic                  req0_ready_o,
  output logic [DATA_WIDTH-1:0] rsp0_rdata_o,
  output logic                  rsp0_err_o,
  output logic                  rsp0_valid_o,
  input  logic [ADDR_WIDTH-1:0] req1_addr_i,
  input  logic [DATA_WIDTH-1:0] req1_wdata_i,
  input  logic                  req1_rw_i,
  input  logic                  req1_valid_i,
  output logic                  req1_ready_o,
  output logic [DATA_WIDTH-1:0] rsp1_rdata_o,
  output logic                  rsp1_err_o,
  output logic                  rsp1_valid_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rw_o,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  input  logic                  rw_i,
  input  logic                  valid_i
);
  localparam int CW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state;
  logic prio, win, grant, gnt_v, last, unused_tail;
  logic [CW-1:0] cnt;
  assign unused_tail = ^{addr_i, wdata_i, rw_i};
  // Priority requester wins if pending, otherwise the other one; only granted while idle
  always_comb begin
    grant = (prio ? req1_valid_i : req0_valid_i) ? prio : !prio;
    gnt_v = state == IDLE && (req0_valid_i || req1_valid_i);
    last  = cnt == CW'(TIMEOUT - 1);
  end
  assign req0_ready_o = gnt_v && !grant;
  assign req1_ready_o = gnt_v && grant;
  // Single-transaction sequencer: issue to chain head, wait for tail or timeout, respond
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      prio         <= 1'b0;
      win          <= 1'b0;
      cnt          <= '0;
      addr_o       <= '0;
      wdata_o      <= '0;
      rdata_o      <= '0;
      rw_o         <= 1'b0;
      valid_o      <= 1'b0;
      rsp0_rdata_o <= '0;
      rsp0_err_o   <= 1'b0;
      rsp0_valid_o <= 1'b0;
      rsp1_rdata_o <= '0;
      rsp1_err_o   <= 1'b0;
      rsp1_valid_o <= 1'b0;
    end else begin
      rdata_o <= '0;
      case (state)
        IDLE: if (gnt_v) begin
          win     <= grant;
          addr_o  <= grant ? req1_addr_i : req0_addr_i;
          wdata_o <= grant ? req1_wdata_i : req0_wdata_i;
          rw_o    <= grant ? req1_rw_i : req0_rw_i;
          valid_o <= 1'b1;
          state   <= ISSUE;
        end
        ISSUE: begin
          addr_o  <= '0;
          wdata_o <= '0;
          rw_o    <= 1'b0;
          valid_o <= 1'b0;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: if (valid_i || last) begin
          rsp0_valid_o <= !win;
          rsp1_valid_o <= win;
          rsp0_rdata_o <= (!win && valid_i) ? rdata_i : '0;
          rsp1_rdata_o <= (win && valid_i) ? rdata_i : '0;
          rsp0_err_o   <= !win && !valid_i;
          rsp1_err_o   <= win && !valid_i;
          state        <= RESP;
        end else begin
          cnt <= cnt + CW'(1);
        end
        RESP: begin
          rsp0_valid_o <= 1'b0;
          rsp1_valid_o <= 1'b0;
          rsp0_rdata_o <= '0;
          rsp1_rdata_o <= '0;
          rsp0_err_o   <= 1'b0;
          rsp1_err_o   <= 1'b0;
          prio         <= !win;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: random requests and tail traffic checked against a timeline model
module tb_bus_arbiter;
  localparam int TO = 16;
  localparam int NC = 3000;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic [15:0] a0, w0, a1, w1, addr_o, wdata_o, rdata_o, addr_in, wdata_in, td_in;
  logic [15:0] rd0, rd1;
  logic rw0, v0, rw1, v1, rdy0, rdy1, er0, er1, rv0, rv1, rw_o, valid_o, rw_in, tv_in;
  bus_arbiter #(.TIMEOUT(TO), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_addr_i(a0), .req0_wdata_i(w0), .req0_rw_i(rw0), .req0_valid_i(v0), .req0_ready_o(rdy0),
    .rsp0_rdata_o(rd0), .rsp0_err_o(er0), .rsp0_valid_o(rv0),
    .req1_addr_i(a1), .req1_wdata_i(w1), .req1_rw_i(rw1), .req1_valid_i(v1), .req1_ready_o(rdy1),
    .rsp1_rdata_o(rd1), .rsp1_err_o(er1), .rsp1_valid_o(rv1),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o),
    .addr_i(addr_in), .wdata_i(wdata_in), .rdata_i(td_in), .rw_i(rw_in), .valid_i(tv_in)
  );
  int total = 0, bad = 0;
  bit tv [0:NC+63];
  logic [15:0] td [0:NC+63];
  logic [15:0] fm [0:23];
  bit p_v [2];
  bit p_rw [2];
  logic [15:0] p_a [2];
  logic [15:0] p_w [2];
  bit m_busy = 0, m_win = 0, m_prio = 0, m_rw = 0, m_err = 0, rst_prev = 0, g, gv, vo;
  int m_t = 0, m_resp = 0, d;
  logic [15:0] m_addr = 0, m_wdata = 0, m_rd = 0, ret;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 24; i++) fm[i] = 16'(i);
    for (int k = 0; k < NC + 64; k++) begin
      tv[k] = (k >= 40) && ($urandom % 40 == 0);
      td[k] = 16'($urandom);
    end
    tv[36] = 1'b1;
    for (int n = 0; n < 2; n++) begin
      p_v[n] = 0; p_rw[n] = 0; p_a[n] = '0; p_w[n] = '0;
    end
    {a0, w0, rw0, v0, a1, w1, rw1, v1} = '0;
    {addr_in, wdata_in, td_in, rw_in, tv_in} = '0;
    for (int c = 0; c < NC; c++) begin
      @(posedge clk);
      #1;
      rst = c < 3 || (c >= 40 && $urandom % 120 == 0);
      if (c == 3) begin
        p_v[0] = 1; p_a[0] = 16'h0003; p_rw[0] = 0;
        p_v[1] = 1; p_a[1] = 16'h000A; p_rw[1] = 0;
      end
      if (c == 15) begin
        p_v[0] = 1; p_a[0] = 16'h0004; p_rw[0] = 0;
      end
      if (c >= 40)
        for (int n = 0; n < 2; n++)
          if (!p_v[n] && $urandom % 3 == 0) begin
            p_v[n] = 1;
            p_a[n] = ($urandom % 8 == 0) ? 16'h0040 : 16'($urandom % 32);
            p_w[n] = 16'($urandom);
            p_rw[n] = 1'($urandom % 2);
          end
      v0 = p_v[0]; a0 = p_a[0]; w0 = p_w[0]; rw0 = p_rw[0];
      v1 = p_v[1]; a1 = p_a[1]; w1 = p_w[1]; rw1 = p_rw[1];
      tv_in = tv[c]; td_in = td[c];
      addr_in = 16'($urandom); wdata_in = 16'($urandom); rw_in = 1'($urandom % 2);
      @(negedge clk);
      if (rst_prev) begin
        m_busy = 0; m_prio = 0;
      end else if (m_busy && c > m_resp) begin
        m_busy = 0; m_prio = !m_win;
      end
      g  = p_v[m_prio] ? m_prio : !m_prio;
      gv = !m_busy && (p_v[0] || p_v[1]);
      vo = m_busy && c == m_t + 1;
      if (c >= 1) begin
        chk("ready0", rdy0, gv && !g);
        chk("ready1", rdy1, gv && g);
        chk("valid_o", valid_o, vo);
        chk("addr_o", addr_o, vo ? m_addr : 16'h0);
        chk("wdata_o", wdata_o, vo ? m_wdata : 16'h0);
        chk("rw_o", rw_o, vo && m_rw);
        chk("rdata_o", rdata_o, 0);
        chk("rsp0_valid", rv0, m_busy && c == m_resp && !m_win);
        chk("rsp0_rdata", rd0, (m_busy && c == m_resp && !m_win) ? m_rd : 16'h0);
        chk("rsp0_err", er0, m_busy && c == m_resp && !m_win && m_err);
        chk("rsp1_valid", rv1, m_busy && c == m_resp && m_win);
        chk("rsp1_rdata", rd1, (m_busy && c == m_resp && m_win) ? m_rd : 16'h0);
        chk("rsp1_err", er1, m_busy && c == m_resp && m_win && m_err);
      end
      if (c == 2) chk("lit_reset_valid_o", valid_o, 0);
      if (c == 3) chk("lit_pair_ready0", {rdy0, rdy1}, 2'b10);
      if (c == 4) chk("lit_issue_addr", {valid_o, addr_o}, 17'h10003);
      if (c == 8) chk("lit_rsp0", {rv0, er0, rd0, rv1}, {1'b1, 1'b0, 16'h0003, 1'b0});
      if (c == 9) chk("lit_pair_ready1", {rdy0, rdy1}, 2'b01);
      if (c == 14) chk("lit_rsp1", {rv1, er1, rd1}, {1'b1, 1'b0, 16'h000A});
      if (c == 32) chk("lit_no_early_timeout", rv0, 0);
      if (c == 33) chk("lit_timeout", {rv0, er0, rd0}, {1'b1, 1'b1, 16'h0000});
      if (c == 37) chk("lit_late_ignored", {rv0, rv1}, 2'b00);
      if (gv && !rst) begin
        m_busy = 1; m_t = c; m_win = g;
        m_addr = p_a[g]; m_wdata = p_w[g]; m_rw = p_rw[g]; p_v[g] = 0;
        ret = m_rw ? m_wdata : (m_addr < 24 ? fm[m_addr[4:0]] : 16'h0);
        if (m_rw && m_addr < 24) fm[m_addr[4:0]] = m_wdata;
        if (c < 40) d = (m_addr == 16'h0004) ? -1 : 3;
        else begin
          case ($urandom % 10)
            0, 1, 2, 3, 4, 5: d = 1 + int'($urandom % 6);
            6: d = TO;
            7: d = 0;
            8: d = TO + 1 + int'($urandom % 4);
            default: d = -1;
          endcase
        end
        if (d >= 0) begin
          tv[c + 1 + d] = 1; td[c + 1 + d] = ret;
        end
        m_err = 1; m_rd = '0; m_resp = c + 2 + TO;
        for (int k = c + TO + 1; k >= c + 2; k--)
          if (tv[k]) begin
            m_resp = k + 1; m_rd = td[k]; m_err = 0;
          end
      end
      rst_prev = rst;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-requester arbiter and sequencer for the daisy-chained 16-bit core bus (addr/wdata/rdata/rw/valid) that threads through the lut_ram cores.
- Accepts one transaction at a time from either requester (e.g. host bridge, on-chip sequencer) and drives it into the head of the chain.
- Waits for the transaction to emerge at the chain tail and returns rdata, or a timeout error, to the requester that issued it.
- Round-robin grant; at most one transaction outstanding on the chain.

Parameters:
- TIMEOUT, 16: WAIT cycles allowed for a chain return before an error response (>=2).
- ADDR_WIDTH, 16: bus address width.
- DATA_WIDTH, 16: bus data width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0_addr_i  in  ADDR_WIDTH  requester 0 address
- req0_wdata_i  in  DATA_WIDTH  requester 0 write data
- req0_rw_i  in  1  requester 0 direction, 1 = write
- req0_valid_i  in  1  requester 0 request pending
- req0_ready_o  out  1  requester 0 request accepted this cycle
- rsp0_rdata_o  out  DATA_WIDTH  response data to requester 0
- rsp0_err_o  out  1  requester 0 transaction timed out
- rsp0_valid_o  out  1  requester 0 response strobe
- req1_* / rsp1_*  same as requester 0, for requester 1
- addr_o, wdata_o, rdata_o  out  ADDR/DATA/DATA  chain head bus
- rw_o, valid_o  out  1  chain head bus
- addr_i, wdata_i, rdata_i  in  ADDR/DATA/DATA  chain tail bus
- rw_i, valid_i  in  1  chain tail bus

Behaviour:
- Reset: state IDLE; priority to req0; all bus outputs, rsp*_o and timeout counter 0.
- Bus and rsp outputs are registered. reqN_ready_o is combinational: state==IDLE and grant==N.
- IDLE:
  - Grant to the priority requester if it is valid, otherwise to the other requester if valid.
  - On grant: ready high for one cycle; latch addr, wdata, rw and the winner id; go to ISSUE.
- ISSUE (1 cycle):
  - valid_o=1 with the latched addr_o, wdata_o, rw_o; rdata_o=0.
  - Go to WAIT and clear the counter.
  - In every other state valid_o=0 and addr_o/wdata_o/rw_o/rdata_o hold 0.
- WAIT:
  - If valid_i: capture rdata_i (write or read alike), err=0, go to RESP.
  - Otherwise increment the counter. When TIMEOUT WAIT cycles have elapsed without valid_i: rdata=0, err=1, go to RESP.
  - valid_i on the final allowed cycle wins over timeout.
- RESP (1 cycle):
  - Winner's rsp_valid=1 with rdata and err; the other requester's rsp_* stay 0.
  - Priority moves to the non-winner; go to IDLE.
- valid_i outside WAIT (stray or late return) is ignored and must not generate a response.
- addr_i/wdata_i/rw_i are not checked; with a single outstanding transaction, the first tail valid is the response.
- Latency:
  - Accept at cycle T; valid_o at T+1.
  - With an N-core registered chain, valid_i arrives at T+1+N and rsp_valid at T+2+N.
  - Back in IDLE at T+3+N, which is the earliest next accept.
- A requester holding valid while not granted keeps its request; its fields must stay stable until ready.
- Reset mid-operation returns to IDLE within one cycle, drops the transaction silently (no rsp), and restores priority to req0.

Test Plan:
- Chain of 3 lut_ram (DEPTH 8, BASE 0/8/16) preloaded mem[i]=base+i; req0 read 0x0001 accepted at T -> valid_o at T+1, rsp0_valid at T+5, rdata 0x0001, err 0.
- req1 write 0x0012 <= 0x0069 -> rsp1_valid, err 0. Then req1 read 0x0012 -> rdata 0x0069, and mem_3.mem[2]==0x0069.
- After reset, req0 (read 0x0003) and req1 (read 0x000A) asserted in the same cycle:
  - req0 served first, rsp0 0x0003; req1 accepted at the next IDLE, rsp1 0x000A.
  - A repeat simultaneous pair is served req0 first again, since priority returned to req0.
- Tail valid_i tied 0, req0 read 0x0004, TIMEOUT=16 -> rsp0_valid exactly 16 WAIT cycles after ISSUE, err 1, rdata 0. A later injected valid_i produces no response.
- Unmapped read 0x0040 -> chain passes it through, rsp rdata 0x0000, err 0.
- rst pulsed during WAIT of a req1 read:
  - All outputs 0 the next cycle and no rsp1_valid from the in-flight return.
  - A subsequent req0 read 0x0005 completes normally with rdata 0x0005.
